// File: rtl/radix2_bfly_pipe.sv
// Three-stage pipelined radix-2 butterfly (standard / modified / inverse) with valid/ready backpressure.
// Define RADIX2_BFLY_SAT_EN to saturate every reduction to bit_width and drive the sticky ovf_flag.
module radix2_bfly_pipe #(
    parameter int bit_width      = 16,
    parameter int word_length_tw = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [1:0]                mode,
    input  logic                      scale_en,
    input  logic [word_length_tw-1:0] cos_data,
    input  logic [word_length_tw-1:0] sin_data,
    input  logic [word_length_tw-1:0] cos_data2,
    input  logic [word_length_tw-1:0] sin_data2,
    input  logic [bit_width-1:0]      Re_i1,
    input  logic [bit_width-1:0]      Im_i1,
    input  logic [bit_width-1:0]      Re_i2,
    input  logic [bit_width-1:0]      Im_i2,
    output logic [bit_width-1:0]      Re_o1,
    output logic [bit_width-1:0]      Im_o1,
    output logic [bit_width-1:0]      Re_o2,
    output logic [bit_width-1:0]      Im_o2,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      ovf_flag
);

    localparam int PW = bit_width + word_length_tw + 1;
    localparam int SH = word_length_tw - 2;
    localparam logic signed [PW-1:0] RND = PW'(2 ** (word_length_tw - 3));
`ifdef RADIX2_BFLY_SAT_EN
    localparam logic signed [PW-1:0] MAXV = PW'(2 ** (bit_width - 1) - 1);
    localparam logic signed [PW-1:0] MINV = -MAXV - PW'(1);
`endif

    // Returns {sat, value}; sat is constant 0 when saturation is compiled out.
    function automatic logic [bit_width:0] reduce(input logic signed [PW-1:0] v);
`ifdef RADIX2_BFLY_SAT_EN
        if (v > MAXV) return {1'b1, MAXV[bit_width-1:0]};
        if (v < MINV) return {1'b1, MINV[bit_width-1:0]};
`endif
        return {1'b0, v[bit_width-1:0]};
    endfunction

    function automatic logic [2*bit_width:0] cmul(
        input logic signed [bit_width-1:0]    xr,
        input logic signed [bit_width-1:0]    xi,
        input logic signed [word_length_tw:0] c,
        input logic signed [word_length_tw:0] s
    );
        logic signed [PW-1:0] xre, xie, ce, se;
        logic [bit_width:0]   rr, ri;
        xre = xr;
        xie = xi;
        ce  = c;
        se  = s;
        rr  = reduce((xre * ce - xie * se + RND) >>> SH);
        ri  = reduce((xie * ce + xre * se + RND) >>> SH);
        return {rr[bit_width] | ri[bit_width], rr[bit_width-1:0], ri[bit_width-1:0]};
    endfunction

    function automatic logic [bit_width:0] finish_sum(
        input logic signed [bit_width:0] sum,
        input logic                      scale
    );
        logic signed [PW-1:0] wide;
        if (scale) return {1'b0, sum[bit_width:1]};
        wide = sum;
        return reduce(wide);
    endfunction

    logic                          advance;
    logic                          s1_valid, s1_mod, s1_scale;
    logic [word_length_tw-1:0]     s1_c2, s1_s2;
    logic signed [bit_width-1:0]   s1_ar, s1_ai, s1_tr, s1_ti;
    logic                          s2_valid, s2_mod, s2_scale;
    logic signed [bit_width-1:0]   s2_ar, s2_ai, s2_tr, s2_ti, s2_ur, s2_ui;
    logic                          ovf_q;

    logic signed [word_length_tw:0] sin1_x, sin1_e;
    logic [2*bit_width:0]           mul1, mul2;
    logic signed [bit_width:0]      sum1r, sum1i, sum2r, sum2i;
    logic [bit_width:0]             o1r, o1i, o2r, o2i;
    logic                           add_sat;

    assign advance  = ~out_valid | out_ready;
    assign in_ready = advance;
    assign ovf_flag = ovf_q;

    always_comb begin
        sin1_x  = {sin_data[word_length_tw-1], sin_data};
        sin1_e  = (mode == 2'b10) ? -sin1_x : sin1_x;
        mul1    = cmul(Re_i2, Im_i2, {cos_data[word_length_tw-1], cos_data}, sin1_e);
        mul2    = cmul(s1_tr, s1_ti, {s1_c2[word_length_tw-1], s1_c2},
                       {s1_s2[word_length_tw-1], s1_s2});
        sum1r   = s2_ar + s2_tr;
        sum1i   = s2_ai + s2_ti;
        sum2r   = s2_mod ? s2_ar + s2_ur : s2_ar - s2_tr;
        sum2i   = s2_mod ? s2_ai + s2_ui : s2_ai - s2_ti;
        o1r     = finish_sum(sum1r, s2_scale);
        o1i     = finish_sum(sum1i, s2_scale);
        o2r     = finish_sum(sum2r, s2_scale);
        o2i     = finish_sum(sum2i, s2_scale);
        add_sat = o1r[bit_width] | o1i[bit_width] | o2r[bit_width] | o2i[bit_width];
    end

    // A single enable freezes the whole pipe, so bubbles keep their slots.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_mod    <= 1'b0;
            s1_scale  <= 1'b0;
            s1_c2     <= '0;
            s1_s2     <= '0;
            s1_ar     <= '0;
            s1_ai     <= '0;
            s1_tr     <= '0;
            s1_ti     <= '0;
            s2_valid  <= 1'b0;
            s2_mod    <= 1'b0;
            s2_scale  <= 1'b0;
            s2_ar     <= '0;
            s2_ai     <= '0;
            s2_tr     <= '0;
            s2_ti     <= '0;
            s2_ur     <= '0;
            s2_ui     <= '0;
            out_valid <= 1'b0;
            Re_o1     <= '0;
            Im_o1     <= '0;
            Re_o2     <= '0;
            Im_o2     <= '0;
            ovf_q     <= 1'b0;
        end else if (advance) begin
            s1_valid  <= in_valid;
            s1_mod    <= (mode == 2'b01);
            s1_scale  <= scale_en;
            s1_c2     <= cos_data2;
            s1_s2     <= sin_data2;
            s1_ar     <= Re_i1;
            s1_ai     <= Im_i1;
            s1_tr     <= mul1[2*bit_width-1:bit_width];
            s1_ti     <= mul1[bit_width-1:0];
            s2_valid  <= s1_valid;
            s2_mod    <= s1_mod;
            s2_scale  <= s1_scale;
            s2_ar     <= s1_ar;
            s2_ai     <= s1_ai;
            s2_tr     <= s1_tr;
            s2_ti     <= s1_ti;
            s2_ur     <= s1_mod ? mul2[2*bit_width-1:bit_width] : s1_tr;
            s2_ui     <= s1_mod ? mul2[bit_width-1:0] : s1_ti;
            out_valid <= s2_valid;
            Re_o1     <= o1r[bit_width-1:0];
            Im_o1     <= o1i[bit_width-1:0];
            Re_o2     <= o2r[bit_width-1:0];
            Im_o2     <= o2i[bit_width-1:0];
            ovf_q     <= ovf_q | (in_valid & mul1[2*bit_width])
                               | (s1_valid & s1_mod & mul2[2*bit_width])
                               | (s2_valid & add_sat);
        end
    end

endmodule

// File: tb/tb_radix2_bfly_pipe.sv
// Self-checking bench for radix2_bfly_pipe: directed test-plan vectors plus randomized streams
// against an integer reference model; honours RADIX2_BFLY_SAT_EN for the expected arithmetic.
module tb_radix2_bfly_pipe;

    localparam int BW = 16;
    localparam int TW = 8;

    logic          clk = 1'b0;
    logic          rst, in_valid, in_ready, scale_en, out_valid, out_ready, ovf_flag;
    logic [1:0]    mode;
    logic [TW-1:0] cos_data, sin_data, cos_data2, sin_data2;
    logic [BW-1:0] Re_i1, Im_i1, Re_i2, Im_i2, Re_o1, Im_o1, Re_o2, Im_o2;

    always #5 clk = ~clk;

    radix2_bfly_pipe #(.bit_width(BW), .word_length_tw(TW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
        .scale_en(scale_en), .cos_data(cos_data), .sin_data(sin_data),
        .cos_data2(cos_data2), .sin_data2(sin_data2),
        .Re_i1(Re_i1), .Im_i1(Im_i1), .Re_i2(Re_i2), .Im_i2(Im_i2),
        .Re_o1(Re_o1), .Im_o1(Im_o1), .Re_o2(Re_o2), .Im_o2(Im_o2),
        .out_valid(out_valid), .out_ready(out_ready), .ovf_flag(ovf_flag)
    );

    typedef struct { int ar, ai, br, bi, c1, s1, c2, s2, mode, sc; } vec_t;
    typedef struct { int o1r, o1i, o2r, o2i; bit ovf; } res_t;

    int   checks = 0;
    int   failures = 0;
    res_t exp_q[$];
    bit   exp_ovf = 1'b0;

`ifdef RADIX2_BFLY_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    function automatic int red(int v, inout bit ov);
        logic signed [15:0] w;
        if (SAT) begin
            if (v > 32767)  begin ov = 1'b1; return 32767;  end
            if (v < -32768) begin ov = 1'b1; return -32768; end
            return v;
        end
        w = v[15:0];
        return int'(w);
    endfunction

    function automatic res_t model(vec_t v);
        res_t r;
        int   s, tr, ti, ur, ui;
        int   sums[4], o[4];
        bit   ov;
        ov = 1'b0;
        s  = (v.mode == 2) ? -v.s1 : v.s1;
        tr = red(((v.br * v.c1 - v.bi * s) + 32) >>> 6, ov);
        ti = red(((v.bi * v.c1 + v.br * s) + 32) >>> 6, ov);
        ur = tr;
        ui = ti;
        if (v.mode == 1) begin
            ur = red(((tr * v.c2 - ti * v.s2) + 32) >>> 6, ov);
            ui = red(((ti * v.c2 + tr * v.s2) + 32) >>> 6, ov);
        end
        sums[0] = v.ar + tr;
        sums[1] = v.ai + ti;
        sums[2] = (v.mode == 1) ? v.ar + ur : v.ar - tr;
        sums[3] = (v.mode == 1) ? v.ai + ui : v.ai - ti;
        for (int i = 0; i < 4; i++) o[i] = (v.sc != 0) ? (sums[i] >>> 1) : red(sums[i], ov);
        r.o1r = o[0]; r.o1i = o[1]; r.o2r = o[2]; r.o2i = o[3]; r.ovf = ov;
        return r;
    endfunction

    function automatic vec_t mkvec(int ar, int ai, int br, int bi, int c1, int s1,
                                   int c2, int s2, int md, int sc);
        vec_t v;
        v.ar = ar; v.ai = ai; v.br = br; v.bi = bi; v.c1 = c1; v.s1 = s1;
        v.c2 = c2; v.s2 = s2; v.mode = md; v.sc = sc;
        return v;
    endfunction

    function automatic vec_t rand_vec();
        return mkvec(int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768,
                     int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768,
                     int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
                     int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
                     int'($urandom_range(0, 3)), int'($urandom_range(0, 1)));
    endfunction

    task automatic apply(input vec_t v);
        Re_i1 = 16'(v.ar); Im_i1 = 16'(v.ai); Re_i2 = 16'(v.br); Im_i2 = 16'(v.bi);
        cos_data = 8'(v.c1); sin_data = 8'(v.s1); cos_data2 = 8'(v.c2); sin_data2 = 8'(v.s2);
        mode = 2'(v.mode); scale_en = (v.sc != 0);
    endtask

    // One isolated sample: checks latency, values against given constants, single-cycle pulse.
    task automatic single(input string tag, input vec_t v, input int e1r, input int e1i,
                          input int e2r, input int e2i);
        int lat;
        apply(v);
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin @(posedge clk); #1; lat++; end
        checks++;
        if (lat !== 3) begin
            failures++;
            $display("FAIL %s latency: got %0d expected 3", tag, lat);
        end
        checks++;
        if ({Re_o1, Im_o1, Re_o2, Im_o2} !== {16'(e1r), 16'(e1i), 16'(e2r), 16'(e2i)}) begin
            failures++;
            $display("FAIL %s data: got (%0d,%0d) (%0d,%0d) expected (%0d,%0d) (%0d,%0d)", tag,
                     $signed(Re_o1), $signed(Im_o1), $signed(Re_o2), $signed(Im_o2), e1r, e1i, e2r, e2i);
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL %s pulse: out_valid=%b expected 0", tag, out_valid);
        end
    endtask

    // rmode: 0 ready always, 1 random ready, 2 stall four cycles once out_valid rises.
    task automatic run_stream(input string tag, input vec_t vs[$], input int rmode, input int maxgap);
        int n;
        n = vs.size();
        fork
            begin
                for (int k = 0; k < n; k++) begin
                    int   g, w;
                    bit   acc;
                    res_t r;
                    g = int'($urandom_range(0, maxgap));
                    repeat (g) begin in_valid = 1'b0; @(posedge clk); #1; end
                    apply(vs[k]);
                    in_valid = 1'b1;
                    acc = 1'b0;
                    w = 0;
                    while (!acc && w < 500) begin
                        @(negedge clk);
                        acc = in_ready;
                        @(posedge clk); #1;
                        w++;
                    end
                    if (acc) begin
                        r = model(vs[k]);
                        exp_q.push_back(r);
                        if (r.ovf) exp_ovf = 1'b1;
                    end else begin
                        checks++;
                        failures++;
                        $display("FAIL %s accept: sample %0d never accepted", tag, k);
                    end
                end
                in_valid = 1'b0;
            end
            begin
                int            got, cyc, stall;
                bit            seen;
                logic [4*BW-1:0] held;
                res_t          e;
                got = 0; cyc = 0; stall = 0; seen = 1'b0; held = '0;
                while (got < n && cyc < 5000) begin
                    if (rmode == 1)      out_ready = ($urandom_range(0, 3) != 0);
                    else if (rmode == 2) out_ready = seen && (stall == 0);
                    else                 out_ready = 1'b1;
                    @(negedge clk);
                    if (rmode == 2 && !seen && out_valid) begin
                        seen = 1'b1;
                        stall = 4;
                        held = {Re_o1, Im_o1, Re_o2, Im_o2};
                    end
                    if (rmode == 2 && stall > 0) begin
                        checks++;
                        if (in_ready !== 1'b0 || out_valid !== 1'b1 ||
                            {Re_o1, Im_o1, Re_o2, Im_o2} !== held) begin
                            failures++;
                            $display("FAIL %s stall: in_ready=%b out_valid=%b data=%h held=%h",
                                     tag, in_ready, out_valid, {Re_o1, Im_o1, Re_o2, Im_o2}, held);
                        end
                        stall--;
                    end
                    if (out_valid && out_ready) begin
                        checks++;
                        if (exp_q.size() == 0) begin
                            failures++;
                            $display("FAIL %s extra: unexpected output %h", tag,
                                     {Re_o1, Im_o1, Re_o2, Im_o2});
                        end else begin
                            e = exp_q.pop_front();
                            if ({Re_o1, Im_o1, Re_o2, Im_o2} !==
                                {16'(e.o1r), 16'(e.o1i), 16'(e.o2r), 16'(e.o2i)}) begin
                                failures++;
                                $display("FAIL %s out %0d: got (%0d,%0d) (%0d,%0d) expected (%0d,%0d) (%0d,%0d)",
                                         tag, got, $signed(Re_o1), $signed(Im_o1), $signed(Re_o2),
                                         $signed(Im_o2), e.o1r, e.o1i, e.o2r, e.o2i);
                            end
                        end
                        got++;
                    end
                    @(posedge clk); #1;
                    cyc++;
                end
                out_ready = 1'b1;
                if (got < n) begin
                    checks++;
                    failures++;
                    $display("FAIL %s timeout: got %0d outputs expected %0d", tag, got, n);
                end
            end
        join
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s leftover: %0d expected outputs never appeared", tag, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        apply(mkvec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || ovf_flag !== 1'b0 ||
            {Re_o1, Im_o1, Re_o2, Im_o2} !== '0) begin
            failures++;
            $display("FAIL reset: out_valid=%b in_ready=%b ovf=%b data=%h expected 0 1 0 0",
                     out_valid, in_ready, ovf_flag, {Re_o1, Im_o1, Re_o2, Im_o2});
        end
    endtask

    task automatic test_directed();
        single("std",      mkvec(100, 50, 20, -10, 64, 0, 0, 0, 0, 0),   120, 40, 80, 60);
        single("minus_j",  mkvec(100, 50, 20, -10, 0, -64, 0, 0, 0, 0),  90, 30, 110, 70);
        single("inverse",  mkvec(100, 50, 20, -10, 0, -64, 0, 0, 2, 0),  110, 70, 90, 30);
        single("modified", mkvec(100, 50, 20, -10, 64, 0, 0, 64, 1, 0),  120, 40, 110, 70);
        single("mod_scale", mkvec(100, 50, 20, -10, 64, 0, 0, 64, 1, 1), 60, 20, 55, 35);
        single("mode11",   mkvec(100, 50, 20, -10, 64, 0, 0, 64, 3, 0),  120, 40, 80, 60);
    endtask

    task automatic test_overflow();
        single("overflow", mkvec(32767, 0, 100, 0, 64, 0, 0, 0, 0, 0),
               SAT ? 32767 : -32669, 0, 32667, 0);
        checks++;
        if (ovf_flag !== SAT) begin
            failures++;
            $display("FAIL ovf_set: ovf_flag=%b expected %b", ovf_flag, SAT);
        end
        single("post_ovf", mkvec(100, 50, 20, -10, 64, 0, 0, 0, 0, 0), 120, 40, 80, 60);
        checks++;
        if (ovf_flag !== SAT) begin
            failures++;
            $display("FAIL ovf_sticky: ovf_flag=%b expected %b", ovf_flag, SAT);
        end
        exp_ovf = SAT;
    endtask

    task automatic test_back_to_back();
        vec_t vs[$];
        for (int i = 0; i < 5; i++) vs.push_back(rand_vec());
        run_stream("b2b", vs, 2, 0);
    endtask

    task automatic test_random();
        vec_t vs[$];
        for (int i = 0; i < 300; i++) vs.push_back(rand_vec());
        run_stream("random", vs, 1, 2);
        checks++;
        if (ovf_flag !== exp_ovf) begin
            failures++;
            $display("FAIL random_ovf: ovf_flag=%b expected %b", ovf_flag, exp_ovf);
        end
    endtask

    task automatic test_reset_midstream();
        bit stale;
        out_ready = 1'b1;
        apply(rand_vec()); in_valid = 1'b1;
        @(posedge clk); #1;
        apply(rand_vec());
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_ovf = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || ovf_flag !== 1'b0 ||
            {Re_o1, Im_o1, Re_o2, Im_o2} !== '0) begin
            failures++;
            $display("FAIL mid_reset: out_valid=%b in_ready=%b ovf=%b data=%h expected 0 1 0 0",
                     out_valid, in_ready, ovf_flag, {Re_o1, Im_o1, Re_o2, Im_o2});
        end
        stale = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) stale = 1'b1;
        end
        @(posedge clk); #1;
        checks++;
        if (stale !== 1'b0) begin
            failures++;
            $display("FAIL stale: out_valid seen after reset, got 1 expected 0");
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_overflow();
        test_back_to_back();
        test_random();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
